// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM model: command encodings, controller
// states and a counter-width helper.
package burst_ram_pkg;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WRITE,
        READ_WAIT,
        READ
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_ram_array.sv
// Single-port byte-enabled storage with one cycle of read latency.
// Not reset, so contents survive a controller reset.
module burst_ram_array #(
    parameter int unsigned DATA_BITWIDTH  = 64,
    parameter int unsigned DEPTH_BITWIDTH = 12
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic                       we,
    input  logic [DEPTH_BITWIDTH-1:0]  addr,
    input  logic [DATA_BITWIDTH-1:0]   wr_data,
    input  logic [DATA_BITWIDTH/8-1:0] byte_we,
    output logic [DATA_BITWIDTH-1:0]   rd_data
);

    localparam int unsigned BYTES = DATA_BITWIDTH / 8;

    logic [DATA_BITWIDTH-1:0] mem [0:(1 << DEPTH_BITWIDTH)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (byte_we[i]) begin
                        mem[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
                    end
                end
            end else begin
                rd_data <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/burst_ram.sv
// Burst RAM model: after a fixed calibration delay, accepts read/write bursts
// of BURST_BEATS consecutive beats with a fixed read latency.
module burst_ram
    import burst_ram_pkg::*;
#(
    parameter int unsigned ADDRESS_BITWIDTH         = 21,
    parameter int unsigned DATA_BITWIDTH            = 64,
    parameter int unsigned DEPTH_BITWIDTH           = 12,
    parameter int unsigned BURST_BEATS              = 4,
    parameter int unsigned CYCLES_BEFORE_INITIATED  = 10,
    parameter int unsigned CYCLES_BEFORE_DATA_VALID = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd,
    input  logic                        cmd_en,
    input  logic [ADDRESS_BITWIDTH-1:0] addr,
    input  logic [DATA_BITWIDTH-1:0]    wr_data,
    input  logic [DATA_BITWIDTH/8-1:0]  data_mask,
    output logic [DATA_BITWIDTH-1:0]    rd_data,
    output logic                        rd_data_valid,
    output logic                        init_calib,
    output logic                        busy
);

    localparam int unsigned INIT_W = cnt_width(CYCLES_BEFORE_INITIATED);
    localparam int unsigned WAIT_W = cnt_width(CYCLES_BEFORE_DATA_VALID - 1);
    localparam int unsigned BEAT_W = cnt_width(BURST_BEATS);

    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(CYCLES_BEFORE_INITIATED - 1);
    // Array read is issued one cycle before its beat is shown on rd_data.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CYCLES_BEFORE_DATA_VALID - 2);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_BEATS - 1);

    state_t                      state;
    logic [INIT_W-1:0]           init_cnt;
    logic [WAIT_W-1:0]           wait_cnt;
    logic [BEAT_W-1:0]           beat_cnt;
    logic [DEPTH_BITWIDTH-1:0]   ptr;

    logic [DEPTH_BITWIDTH-1:0]   addr_lo;
    logic                        arr_en;
    logic                        arr_we;
    logic [DEPTH_BITWIDTH-1:0]   arr_addr;
    logic [DATA_BITWIDTH-1:0]    arr_q;
    logic                        unused_addr_hi;

    assign addr_lo        = addr[DEPTH_BITWIDTH-1:0];
    assign unused_addr_hi = ^addr[ADDRESS_BITWIDTH-1:DEPTH_BITWIDTH];

    // Beat 0 of a write goes straight from the ports in the cmd_en cycle.
    always_comb begin
        arr_en   = 1'b0;
        arr_we   = 1'b0;
        arr_addr = ptr;
        case (state)
            IDLE: begin
                if (cmd_en && cmd == CMD_WRITE) begin
                    arr_en   = 1'b1;
                    arr_we   = 1'b1;
                    arr_addr = addr_lo;
                end
            end
            WRITE: begin
                arr_en = 1'b1;
                arr_we = 1'b1;
            end
            READ_WAIT: arr_en = (wait_cnt == WAIT_LAST);
            READ:      arr_en = (beat_cnt != BEAT_LAST);
            default:   arr_en = 1'b0;
        endcase
    end

    burst_ram_array #(
        .DATA_BITWIDTH  (DATA_BITWIDTH),
        .DEPTH_BITWIDTH (DEPTH_BITWIDTH)
    ) u_array (
        .clk     (clk),
        .en      (arr_en),
        .we      (arr_we),
        .addr    (arr_addr),
        .wr_data (wr_data),
        .byte_we (~data_mask),
        .rd_data (arr_q)
    );

    assign rd_data = rd_data_valid ? arr_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= INIT;
            init_cnt      <= '0;
            wait_cnt      <= '0;
            beat_cnt      <= '0;
            ptr           <= '0;
            init_calib    <= 1'b0;
            busy          <= 1'b1;
            rd_data_valid <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state      <= IDLE;
                        init_calib <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_en) begin
                        if (cmd == CMD_WRITE) begin
                            ptr      <= addr_lo + 1'b1;
                            beat_cnt <= BEAT_W'(1);
                            if (BURST_BEATS > 1) begin
                                state <= WRITE;
                                busy  <= 1'b1;
                            end
                        end else if (cmd == CMD_READ) begin
                            ptr      <= addr_lo;
                            wait_cnt <= '0;
                            state    <= READ_WAIT;
                            busy     <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    ptr <= ptr + 1'b1;
                    if (beat_cnt == BEAT_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        ptr           <= ptr + 1'b1;
                        beat_cnt      <= '0;
                        state         <= READ;
                        rd_data_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                READ: begin
                    if (beat_cnt == BEAT_LAST) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        rd_data_valid <= 1'b0;
                    end else begin
                        ptr      <= ptr + 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_ram.sv
// Directed bench for burst_ram: table of write/read bursts with hand-computed
// beats, plus init, busy-ignore, back-to-back and mid-burst reset sequences.
module tb_burst_ram;

    localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] D3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] D4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] HF = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] S5 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] SA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        cmd;
    logic        cmd_en;
    logic [20:0] addr;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic        init_calib;
    logic        busy;

    int tests;
    int failed;

    typedef struct packed {
        logic             is_wr;
        logic [20:0]      addr;
        logic [3:0][63:0] beats;
        logic [3:0][7:0]  mask;
    } vec_t;

    vec_t vecs[15];

    burst_ram #(
        .ADDRESS_BITWIDTH         (21),
        .DATA_BITWIDTH            (64),
        .DEPTH_BITWIDTH           (12),
        .BURST_BEATS              (4),
        .CYCLES_BEFORE_INITIATED  (10),
        .CYCLES_BEFORE_DATA_VALID (6)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd           (cmd),
        .cmd_en        (cmd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .data_mask     (data_mask),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .init_calib    (init_calib),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic w, input logic [20:0] a,
                                 input logic [63:0] b0, input logic [63:0] b1,
                                 input logic [63:0] b2, input logic [63:0] b3,
                                 input logic [31:0] m);
        vec_t v;
        v.is_wr = w;
        v.addr  = a;
        v.beats = {b3, b2, b1, b0};
        v.mask  = m;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Holds reset, releases it and follows init_calib/busy for ten edges.
    task automatic do_init(input bit spam, input string tag);
        rst_n  = 1'b0;
        cmd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            check($sformatf("%s_calib_c%0d", tag, j), 64'(init_calib), 64'(j >= 10));
            check($sformatf("%s_busy_c%0d", tag, j), 64'(busy), 64'(j < 10));
            if (spam && j < 10) begin
                cmd = 1'b1; cmd_en = 1'b1; addr = 21'h050; wr_data = JUNK; data_mask = '0;
            end else begin
                cmd_en = 1'b0;
            end
            if (j < 10) @(negedge clk);
        end
    endtask

    // Called and returns at a negedge; returns in the first idle cycle.
    task automatic do_write(input logic [20:0] a, input logic [3:0][63:0] d,
                            input logic [3:0][7:0] m, input string tag);
        cmd = 1'b1; cmd_en = 1'b1; addr = a; wr_data = d[0]; data_mask = m[0];
        @(negedge clk);
        cmd_en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            wr_data = d[k]; data_mask = m[k];
            check($sformatf("%s_busy_b%0d", tag, k), 64'(busy), 64'(1));
            @(negedge clk);
        end
        check($sformatf("%s_busy_end", tag), 64'(busy), 64'(0));
        wr_data = '0; data_mask = '0;
    endtask

    // Valid must be low for cycles 1..5, high with beats in 6..9, low at 10.
    task automatic do_read(input logic [20:0] a, input logic [3:0][63:0] e,
                           input bit spam, input string tag);
        logic        ev;
        logic [63:0] ed;
        cmd = 1'b0; cmd_en = 1'b1; addr = a;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            ev = (j >= 6 && j <= 9);
            ed = '0;
            if (ev) ed = e[j-6];
            check($sformatf("%s_valid_c%0d", tag, j), 64'(rd_data_valid), 64'(ev));
            check($sformatf("%s_data_c%0d", tag, j), rd_data, ed);
            check($sformatf("%s_busy_c%0d", tag, j), 64'(busy), 64'(j <= 9));
            if (spam && j <= 9) begin
                cmd = 1'b1; cmd_en = 1'b1; addr = a; wr_data = JUNK; data_mask = '0;
            end else begin
                cmd_en = 1'b0;
            end
        end
    endtask

    initial begin
        logic [3:0][63:0] d;
        tests = 0;
        failed = 0;
        rst_n = 1'b0; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '0;

        vecs[0]  = mkv(1, 21'h010, D1, D2, D3, D4, 32'h0);
        vecs[1]  = mkv(0, 21'h010, D1, D2, D3, D4, 32'h0);
        vecs[2]  = mkv(0, 21'h100010, D1, D2, D3, D4, 32'h0);
        vecs[3]  = mkv(1, 21'h020, FF, FF, FF, FF, 32'h0);
        vecs[4]  = mkv(1, 21'h020, '0, '0, '0, '0, 32'hF0F0_F0F0);
        vecs[5]  = mkv(0, 21'h020, HF, HF, HF, HF, 32'h0);
        vecs[6]  = mkv(1, 21'h002, 64'hC0, 64'hC1, 64'hC2, 64'hC3, 32'h0);
        vecs[7]  = mkv(1, 21'hFFE, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 32'h0);
        vecs[8]  = mkv(0, 21'h000, 64'hA2, 64'hA3, 64'hC0, 64'hC1, 32'h0);
        vecs[9]  = mkv(0, 21'hFFE, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 32'h0);
        vecs[10] = mkv(1, 21'h040, S5, S5, S5, S5, 32'h0);
        vecs[11] = mkv(1, 21'h040, SA, SA, SA, SA, 32'hFF00_8001);
        vecs[12] = mkv(0, 21'h040, 64'hAAAA_AAAA_AAAA_AA55, 64'h55AA_AAAA_AAAA_AAAA, SA, S5, 32'h0);
        vecs[13] = mkv(1, 21'h030, 64'h0D0, 64'h0D1, 64'h0D2, 64'h0D3, 32'h0);
        vecs[14] = mkv(1, 21'h050, 64'hB0, 64'hB1, 64'hB2, 64'hB3, 32'h0);

        @(negedge clk);
        #1;
        check("rst_calib", 64'(init_calib), 64'(0));
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_valid", 64'(rd_data_valid), 64'(0));
        check("rst_data", rd_data, '0);
        @(negedge clk);
        do_init(1'b0, "init1");

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].beats, vecs[i].mask, $sformatf("v%0d", i));
            else
                do_read(vecs[i].addr, vecs[i].beats, 1'b0, $sformatf("v%0d", i));
        end

        // Commands during a read are ignored; the next idle cycle accepts one.
        do_read(21'h010, vecs[1].beats, 1'b1, "spam_rd");
        do_read(21'h010, vecs[1].beats, 1'b0, "b2b_rd");

        // Reset in the cycle beat 2 of a write to 0x30 would be presented.
        cmd = 1'b1; cmd_en = 1'b1; addr = 21'h030; wr_data = 64'hE0; data_mask = '0;
        @(negedge clk);
        cmd_en = 1'b0; wr_data = 64'hE1;
        @(negedge clk);
        wr_data = 64'hE2;
        rst_n = 1'b0;
        #1;
        check("midrst_calib", 64'(init_calib), 64'(0));
        check("midrst_busy", 64'(busy), 64'(1));
        check("midrst_valid", 64'(rd_data_valid), 64'(0));
        check("midrst_data", rd_data, '0);
        do_init(1'b1, "init2");

        d = {64'h0D3, 64'h0D2, 64'hE1, 64'hE0};
        do_read(21'h030, d, 1'b0, "rd_30");
        do_read(21'h050, vecs[14].beats, 1'b0, "rd_50");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/burst_ram.md
BURST_RAM -- requirements
Module: burst_ram

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 21, width of addr.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 64, beat width; mask width = DATA_BITWIDTH/8.
REQ-003 SHALL have parameter DEPTH_BITWIDTH, default 12, log2 of stored beats.
REQ-004 SHALL have parameter BURST_BEATS, default 4, beats per command.
REQ-005 SHALL have parameter CYCLES_BEFORE_INITIATED, default 10, cycles from reset release to init_calib.
REQ-006 SHALL have parameter CYCLES_BEFORE_DATA_VALID, default 6, cycles from read cmd_en to first valid beat; legal range 2..15.
REQ-007 SHALL have port clk, input, 1, the single clock, rising edge.
REQ-008 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-009 SHALL have port cmd, input, 1, 0 = read, 1 = write, sampled with cmd_en.
REQ-010 SHALL have port cmd_en, input, 1, command and addr valid this cycle.
REQ-011 SHALL have port addr, input, ADDRESS_BITWIDTH, beat address of burst start.
REQ-012 SHALL have port wr_data, input, DATA_BITWIDTH, write beat data.
REQ-013 SHALL have port data_mask, input, DATA_BITWIDTH/8, bit i = 1 suppresses write of byte i.
REQ-014 SHALL have port rd_data, output, DATA_BITWIDTH, read beat data.
REQ-015 SHALL have port rd_data_valid, output, 1, rd_data holds a valid beat.
REQ-016 SHALL have port init_calib, output, 1, block ready for commands.
REQ-017 SHALL have port busy, output, 1, command in progress; new cmd_en ignored.

Function
REQ-018 SHALL implement states INIT, IDLE, WRITE, READ_WAIT, READ.
REQ-019 INIT: count CYCLES_BEFORE_INITIATED clk edges after rst_n rises, then set init_calib = 1 and enter IDLE; init_calib SHALL stay 1 until next reset.
REQ-020 cmd_en SHALL be accepted only in IDLE; cmd_en in any other state SHALL be ignored with no side effect.
REQ-021 Beat k of a burst (k = 0..BURST_BEATS-1) SHALL address (addr + k) mod 2^DEPTH_BITWIDTH; addr bits above DEPTH_BITWIDTH ignored.
REQ-022 Write: beat 0 = wr_data/data_mask in the cmd_en cycle; beats 1..BURST_BEATS-1 = wr_data/data_mask in the following consecutive cycles (state WRITE); then IDLE.
REQ-023 Read: accept -> READ_WAIT; rd_data_valid SHALL be 1 for exactly BURST_BEATS consecutive cycles, first beat exactly CYCLES_BEFORE_DATA_VALID cycles after cmd_en cycle (state READ); then IDLE.
REQ-024 rd_data SHALL be 0 whenever rd_data_valid = 0.
REQ-025 busy SHALL be 1 from the cycle after an accepted cmd_en through the last beat cycle, 0 in the next cycle; busy = 1 in INIT.
REQ-026 A read of a beat written by a completed burst SHALL return the written bytes; masked bytes SHALL keep prior contents.
REQ-027 Back-to-back: cmd_en in the first cycle busy = 0 after a burst SHALL be accepted.

Reset
REQ-028 On rst_n = 0, asynchronously: state INIT, counters 0, init_calib 0, busy 1, rd_data_valid 0, rd_data 0.
REQ-029 Reset mid-burst SHALL abort the burst; beats already written SHALL be retained, remaining beats not written; storage array SHALL NOT be cleared by reset.

Structure
REQ-030 Command encodings (CMD_READ = 0, CMD_WRITE = 1) and the state enum SHALL live in shared package burst_ram_pkg, also used by RAMIO.
REQ-031 Storage SHALL be sub-module burst_ram_array: single-port, byte-enabled, 1-cycle read latency, inferable as block RAM.

Verification
REQ-032 Reset release -> init_calib 0 for 10 cycles, 1 on cycle 10; busy 1 until then; cmd_en during INIT ignored (later read of same addr returns prior data).
REQ-033 Write addr 0x10 beats 0x1111..., 0x2222..., 0x3333..., 0x4444..., mask 0; read addr 0x10 -> rd_data_valid first at cycle +6, beats 0x1111...,0x2222...,0x3333...,0x4444... on 4 consecutive cycles.
REQ-034 Write addr 0x20 all 0xFF bytes, then write addr 0x20 data 0 mask 0xF0 -> read beat 0 = 0xFFFFFFFF_00000000.
REQ-035 Write at addr 0xFFE (DEPTH_BITWIDTH 12) -> beats at 0xFFE, 0xFFF, 0x000, 0x001; read addr 0x000 returns beats 2,3 first.
REQ-036 cmd_en asserted while busy during a read -> ignored, exactly 4 valid beats; cmd_en on first busy = 0 cycle accepted.
REQ-037 rst_n low after beat 1 of a write to 0x30 -> outputs at reset values immediately; after re-init, 0x30/0x31 hold new data, 0x32/0x33 old data.
